rollback_controller: RTL

Collects rollback, suspend and retry events from the execute and writeback stages for a single strand. Generates the per-stage flush strobes and a registered restart request and PC for the instruction fetch stage. Holds the strand suspended across data-cache misses and store-buffer stalls until the cache signals resume. Sits directly downstream of the writeback stage and feeds the fetch and pipeline-control logic.

---
 rtl/rollback_controller_if.sv | 35 +++
 rtl/rollback_controller.sv | 97 +++++++++
 2 files changed

// File: rtl/rollback_controller_if.sv
// Execute/writeback rollback event inputs and flush/restart outputs of the
// strand rollback controller.
interface rollback_controller_if;
  logic        ex_rollback_request;
  logic [31:0] ex_rollback_pc;
  logic        wb_rollback_request;
  logic [31:0] wb_rollback_pc;
  logic        wb_suspend_request;
  logic        wb_retry;
  logic        dcache_resume;
  logic        retire;
  logic        flush_if;
  logic        flush_ds;
  logic        flush_ex;
  logic        flush_ma;
  logic        restart_request;
  logic [31:0] restart_pc;
  logic        strand_suspended;
  logic        retry_starved;
  logic [31:0] rollback_count;

  modport master (
    output ex_rollback_request, ex_rollback_pc, wb_rollback_request, wb_rollback_pc,
           wb_suspend_request, wb_retry, dcache_resume, retire,
    input  flush_if, flush_ds, flush_ex, flush_ma, restart_request, restart_pc,
           strand_suspended, retry_starved, rollback_count
  );

  modport slave (
    input  ex_rollback_request, ex_rollback_pc, wb_rollback_request, wb_rollback_pc,
           wb_suspend_request, wb_retry, dcache_resume, retire,
    output flush_if, flush_ds, flush_ex, flush_ma, restart_request, restart_pc,
           strand_suspended, retry_starved, rollback_count
  );
endinterface

// File: rtl/rollback_controller.sv
// Single-strand rollback controller: arbitrates ex/wb rollbacks, produces stage
// flushes, a registered fetch restart, strand suspension and a retry livelock flag.
module rollback_controller #(
  parameter int unsigned RETRY_WIDTH = 4,
  parameter int unsigned RETRY_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rollback_controller_if.slave bus
);

  typedef enum logic [0:0] {RUN = 1'b0, SUSPENDED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic                   restart_request_q, restart_request_d;
  logic [31:0]            restart_pc_q, restart_pc_d;
  logic [31:0]            saved_pc_q, saved_pc_d;
  logic [31:0]            rollback_count_q, rollback_count_d;
  logic [RETRY_WIDTH-1:0] retry_cnt_q, retry_cnt_d;
  logic                   retry_starved_q, retry_starved_d;

  logic wb_accept;
  logic ex_accept;
  logic suspend_go;
  logic resume_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= RUN;
      restart_request_q <= 1'b0;
      restart_pc_q      <= '0;
      saved_pc_q        <= '0;
      rollback_count_q  <= '0;
      retry_cnt_q       <= '0;
      retry_starved_q   <= 1'b0;
    end else begin
      state_q           <= state_d;
      restart_request_q <= restart_request_d;
      restart_pc_q      <= restart_pc_d;
      saved_pc_q        <= saved_pc_d;
      rollback_count_q  <= rollback_count_d;
      retry_cnt_q       <= retry_cnt_d;
      retry_starved_q   <= retry_starved_d;
    end
  end

  always_comb begin
    wb_accept  = (state_q == RUN) && bus.wb_rollback_request;
    ex_accept  = (state_q == RUN) && !bus.wb_rollback_request && bus.ex_rollback_request;
    // A resume coinciding with the suspending rollback restarts at once (no lost wakeup).
    suspend_go = wb_accept && bus.wb_suspend_request && !bus.dcache_resume;
    resume_go  = (state_q == SUSPENDED) && bus.dcache_resume;

    state_d = state_q;
    if (suspend_go) begin
      state_d = SUSPENDED;
    end else if (resume_go) begin
      state_d = RUN;
    end

    restart_request_d = ex_accept || (wb_accept && !suspend_go) || resume_go;
    restart_pc_d      = restart_pc_q;
    if (wb_accept) begin
      restart_pc_d = bus.wb_rollback_pc;
    end else if (ex_accept) begin
      restart_pc_d = bus.ex_rollback_pc;
    end else if (resume_go) begin
      restart_pc_d = saved_pc_q;
    end

    saved_pc_d       = suspend_go ? bus.wb_rollback_pc : saved_pc_q;
    rollback_count_d = (wb_accept || ex_accept) ? rollback_count_q + 32'd1 : rollback_count_q;

    retry_cnt_d = retry_cnt_q;
    if (wb_accept && bus.wb_retry) begin
      if (retry_cnt_q != '1) begin
        retry_cnt_d = retry_cnt_q + 1'b1;
      end
    end else if (bus.retire && !bus.wb_rollback_request) begin
      retry_cnt_d = '0;
    end
    retry_starved_d = (retry_cnt_q >= RETRY_WIDTH'(RETRY_LIMIT));
  end

  always_comb begin
    bus.flush_ex         = bus.wb_rollback_request;
    bus.flush_ma         = bus.wb_rollback_request;
    bus.flush_if         = bus.wb_rollback_request || (bus.ex_rollback_request && (state_q == RUN));
    bus.flush_ds         = bus.flush_if;
    bus.restart_request  = restart_request_q;
    bus.restart_pc       = restart_pc_q;
    bus.strand_suspended = (state_q == SUSPENDED);
    bus.retry_starved    = retry_starved_q;
    bus.rollback_count   = rollback_count_q;
  end

endmodule
